q2_control: RTL

Instruction sequencer and front-panel controller for the Q2 bit-slice machine. It drives the per-bit strobe and select lines shared by all slices (A, X, P and S register control, bus enables) and the memory read/write strobes. It sequences a fetch/address/execute cycle for each two-word instruction and handles the load-address, deposit and examine panel operations while the machine is halted.

---
 rtl/q2_control.sv | 137 +++++++++++++
 1 files changed

// File: rtl/q2_control.sv
// Q2 bit-slice instruction sequencer and front-panel controller.
// Optional single-step port enabled by defining Q2_SINGLE_STEP_EN.
module q2_control #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             stop,
  input  logic             load_addr,
  input  logic             deposit,
  input  logic             examine,
`ifdef Q2_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [WIDTH-1:0] dbus_in,
  input  logic             a_zero,
  output logic             dep,
  output logic             rda,
  output logic             rdp,
  output logic             rdx,
  output logic             xin_zero,
  output logic             xin_shift,
  output logic             xin_p,
  output logic             xin_dbus,
  output logic             wra,
  output logic             wrx,
  output logic             wrp,
  output logic             wrs,
  output logic             incp,
  output logic             panel_rst,
  output logic [1:0]       alu_op,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             halted
);

  typedef enum logic [3:0] {
    S_IDLE, S_LDADDR, S_DEPOSIT, S_DEP_INC, S_EXAMINE, S_EXAM_INC,
    S_FETCH_OP, S_INC1, S_FETCH_ADDR, S_INC2, S_EXEC
  } state_t;

  localparam logic [2:0] OP_LD = 3'd0, OP_ST = 3'd1, OP_NOR = 3'd2, OP_ADD = 3'd3,
                         OP_JMP = 3'd4, OP_JZ = 3'd5, OP_HLT = 3'd6;

  state_t     state_q, state_d;
  logic       phase_q;   // 0 = SETUP, 1 = STROBE
  logic [2:0] opc_q;
  logic       stop_q, step_q, az_q;
  logic       done, step_go;

  logic unused_dbus;
  assign unused_dbus = ^dbus_in[WIDTH-4:0];

`ifdef Q2_SINGLE_STEP_EN
  assign step_go = step & ~run;
`else
  assign step_go = 1'b0;
`endif

  // Instruction boundary: end of EXEC, or end of INC1 for the one-word HLT.
  assign done = phase_q & ((state_q == S_EXEC) | ((state_q == S_INC1) & (opc_q == OP_HLT)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      opc_q   <= 3'd0;
      stop_q  <= 1'b0;
      step_q  <= 1'b0;
      az_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= (state_q != S_IDLE) ? ~phase_q : 1'b0;
      if (state_q == S_FETCH_OP && phase_q) opc_q <= dbus_in[WIDTH-1 -: 3];
      if (state_q == S_EXEC && !phase_q)    az_q  <= a_zero;
      if (done)                             stop_q <= 1'b0;
      else if (stop && state_q != S_IDLE)   stop_q <= 1'b1;
      if (state_q == S_IDLE)                step_q <= step_go;
      else if (done)                        step_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run | step_go)  state_d = S_FETCH_OP;
        else if (load_addr) state_d = S_LDADDR;
        else if (deposit)   state_d = S_DEPOSIT;
        else if (examine)   state_d = S_EXAMINE;
      end
      S_LDADDR:     if (phase_q) state_d = S_IDLE;
      S_DEPOSIT:    if (phase_q) state_d = S_DEP_INC;
      S_DEP_INC:    if (phase_q) state_d = S_IDLE;
      S_EXAMINE:    if (phase_q) state_d = S_EXAM_INC;
      S_EXAM_INC:   if (phase_q) state_d = S_IDLE;
      S_FETCH_OP:   if (phase_q) state_d = S_INC1;
      S_INC1:       if (phase_q) state_d = (opc_q == OP_HLT) ? S_IDLE : S_FETCH_ADDR;
      S_FETCH_ADDR: if (phase_q) state_d = S_INC2;
      S_INC2:       if (phase_q) state_d = S_EXEC;
      S_EXEC:       if (phase_q) state_d = (stop_q | stop | step_q) ? S_IDLE : S_FETCH_OP;
      default:      state_d = S_IDLE;
    endcase
  end

  // Enables/selects are held across both phases; strobes only in STROBE.
  always_comb begin
    dep = 1'b0; rda = 1'b0; rdp = 1'b0; rdx = 1'b0;
    xin_zero = 1'b0; xin_shift = 1'b0; xin_p = 1'b0; xin_dbus = 1'b0;
    wra = 1'b0; wrx = 1'b0; wrp = 1'b0; wrs = 1'b0; incp = 1'b0;
    panel_rst = 1'b0; alu_op = 2'b00; mem_rd = 1'b0; mem_wr = 1'b0;
    halted = (state_q == S_IDLE);
    case (state_q)
      S_LDADDR:  panel_rst = 1'b1;
      S_DEPOSIT: begin dep = 1'b1; rdp = 1'b1; mem_wr = phase_q; end
      S_EXAMINE: begin rdp = 1'b1; mem_rd = 1'b1; end
      S_DEP_INC, S_EXAM_INC, S_INC1, S_INC2: incp = phase_q;
      S_FETCH_OP: begin rdp = 1'b1; mem_rd = 1'b1; end
      S_FETCH_ADDR: begin rdp = 1'b1; mem_rd = 1'b1; xin_dbus = 1'b1; wrx = phase_q; end
      S_EXEC: begin
        // X carries the operand address / jump target on abus.
        case (opc_q)
          OP_LD:  begin rdx = 1'b1; mem_rd = 1'b1; alu_op = 2'b00; wra = phase_q; end
          OP_ST:  begin rdx = 1'b1; rda = 1'b1; mem_wr = phase_q; end
          OP_NOR: begin rdx = 1'b1; mem_rd = 1'b1; alu_op = 2'b01; wra = phase_q; end
          OP_ADD: begin rdx = 1'b1; mem_rd = 1'b1; alu_op = 2'b10; wra = phase_q; wrs = phase_q; end
          OP_JMP: begin rdx = 1'b1; wrp = phase_q; end
          OP_JZ:  begin rdx = 1'b1; wrp = phase_q & az_q; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
